pc_unit: RTL and testbench

// - Program-counter register plus next-PC selection for the single-cycle/multicycle MIPS core.
// - Supersedes the combinational PC increment with a parametrised, clocked block.
// - Supports configurable step, reset vector and memory depth, and owns the sequential, branch,

---
 rtl/pc_unit_pkg.sv | 14 +
 rtl/pc_unit_next_sel.sv | 47 ++++
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and the
// default address width / imem depth also used by the instruction memory.
package pc_unit_pkg;

   typedef enum logic [1:0] {
      PC_IDLE = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_e;

   localparam int PC_WIDTH_DEF = 32;
   localparam int PC_DEPTH_DEF = 256;

endpackage

// File: rtl/pc_unit_next_sel.sv
// Next-PC candidate selection: priority mux (stall > jr > jump > branch > seq),
// the pc+STEP adder and the out-of-range compare against DEPTH.
module pc_unit_next_sel
   import pc_unit_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH_DEF,
   parameter int STEP  = 1,
   parameter int DEPTH = PC_DEPTH_DEF
) (
   input  logic [WIDTH-1:0] pc_i,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   input  logic [WIDTH-1:0] branch_offset_i,
   input  logic             jump_i,
   input  logic [WIDTH-1:0] jump_target_i,
   input  logic             jr_i,
   input  logic [WIDTH-1:0] jr_addr_i,
   output logic [WIDTH-1:0] pc_plus_o,
   output logic [WIDTH-1:0] next_pc_o,
   output logic             out_of_range_o
);

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

   logic [WIDTH-1:0] branch_target;

   // Offset is in instruction units, so scale by STEP; all sums wrap mod 2^WIDTH.
   assign pc_plus_o     = pc_i + STEP_W;
   assign branch_target = pc_plus_o + (branch_offset_i * STEP_W);

   always_comb begin
      next_pc_o = pc_plus_o;
      if (stall_i) begin
         next_pc_o = pc_i;
      end else if (jr_i) begin
         next_pc_o = jr_addr_i;
      end else if (jump_i) begin
         next_pc_o = jump_target_i;
      end else if (branch_taken_i) begin
         next_pc_o = branch_target;
      end
   end

   assign out_of_range_o = (next_pc_o >= DEPTH_W);

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with IDLE/RUN/HALT control and sticky range error.
// Handshake: none; pc_valid=1 means the fetch at pc may commit this cycle.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int              WIDTH        = PC_WIDTH_DEF,
   parameter int              STEP         = 1,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int              DEPTH        = PC_DEPTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_addr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             pc_valid,
   output logic             halted,
   output logic             range_err,
   output logic [1:0]       state_dbg
);

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             range_err_q, range_err_d;
   logic [WIDTH-1:0] next_pc;
   logic             out_of_range;

   pc_unit_next_sel #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .DEPTH (DEPTH)
   ) u_next_sel (
      .pc_i            (pc_q),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_offset_i (branch_offset),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .jr_i            (jr),
      .jr_addr_i       (jr_addr),
      .pc_plus_o       (pc_plus),
      .next_pc_o       (next_pc),
      .out_of_range_o  (out_of_range)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= PC_IDLE;
         pc_q        <= RESET_VECTOR;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         range_err_q <= range_err_d;
      end
   end

   // Halt beats every redirect (and stall); a stalled edge never flags a range error.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      range_err_d = range_err_q;
      case (state_q)
         PC_IDLE: state_d = PC_RUN;
         PC_RUN: begin
            if (halt_req) begin
               state_d = PC_HALT;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (out_of_range) begin
               range_err_d = 1'b1;
               state_d     = PC_HALT;
            end else begin
               pc_d = next_pc;
            end
         end
         PC_HALT: state_d = PC_HALT;
         default: state_d = PC_HALT;
      endcase
   end

   assign pc        = pc_q;
   assign pc_valid  = (state_q == PC_RUN);
   assign halted    = (state_q == PC_HALT);
   assign range_err = range_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: three instances cover default parameters,
// a 16-entry imem for range checks, and byte addressing from 0x400.
module tb_pc_unit;

   logic        clock = 1'b0;
   logic        rst0, rst1, rst2;
   logic        stall, halt_req, branch_taken, jump, jr;
   logic [31:0] branch_offset, jump_target, jr_addr;

   logic [31:0] pc0, pp0, pc1, pp1, pc2, pp2;
   logic        v0, h0, e0, v1, h1, e1, v2, h2, e2;
   logic [1:0]  s0, s1, s2;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   pc_unit u_dut0 (
      .clock(clock), .reset(rst0), .stall(stall), .halt_req(halt_req),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
      .pc(pc0), .pc_plus(pp0), .pc_valid(v0), .halted(h0),
      .range_err(e0), .state_dbg(s0)
   );

   pc_unit #(.DEPTH(16)) u_dut1 (
      .clock(clock), .reset(rst1), .stall(stall), .halt_req(halt_req),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
      .pc(pc1), .pc_plus(pp1), .pc_valid(v1), .halted(h1),
      .range_err(e1), .state_dbg(s1)
   );

   pc_unit #(.STEP(4), .RESET_VECTOR(32'h400), .DEPTH(4096)) u_dut2 (
      .clock(clock), .reset(rst2), .stall(stall), .halt_req(halt_req),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
      .pc(pc2), .pc_plus(pp2), .pc_valid(v2), .halted(h2),
      .range_err(e2), .state_dbg(s2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ctrl();
      stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
      branch_offset = '0; jump_target = '0; jr_addr = '0;
   endtask

   initial begin
      rst0 = 1; rst1 = 1; rst2 = 1;
      clear_ctrl();

      // ---- default instance: reset and sequential start ----
      #12;
      check("rst_pc", pc0, 32'd0);
      check("rst_valid", {31'd0, v0}, 32'd0);
      check("rst_halted", {31'd0, h0}, 32'd0);
      check("rst_rerr", {31'd0, e0}, 32'd0);
      check("rst_state", {30'd0, s0}, 32'd0);
      @(posedge clock); #1;
      rst0 = 0;
      check("idle_valid", {31'd0, v0}, 32'd0);
      tick(); check("run_pc0", pc0, 32'd0); check("run_valid", {31'd0, v0}, 32'd1);
      tick(); check("seq_pc1", pc0, 32'd1);
      tick(); check("seq_pc2", pc0, 32'd2); check("pc_plus3", pp0, 32'd3);
      tick(); check("seq_pc3", pc0, 32'd3);
      tick(); tick(); check("seq_pc5", pc0, 32'd5);

      // ---- branches ----
      branch_taken = 1; branch_offset = -32'sd3;
      tick(); check("br_neg", pc0, 32'd3);
      branch_taken = 0;
      tick(); tick(); check("back_pc5", pc0, 32'd5);
      stall = 1; branch_taken = 1; branch_offset = 32'd10;
      tick(); check("stall_hold", pc0, 32'd5);
      stall = 0;
      tick(); check("br_pos", pc0, 32'd16);
      branch_taken = 0;

      // ---- priority jr > jump > branch ----
      jump = 1; jump_target = 32'd8;
      tick(); check("jump8", pc0, 32'd8);
      jr = 1; jr_addr = 32'd40; jump_target = 32'd20; branch_taken = 1;
      tick(); check("prio_jr", pc0, 32'd40);
      jr = 0;
      tick(); check("prio_jump", pc0, 32'd20);
      branch_taken = 0; jump_target = 32'd7;
      tick(); check("jump7", pc0, 32'd7);

      // ---- halt with concurrent redirect, then async reset ----
      halt_req = 1; jump_target = 32'd30;
      tick(); check("halt_pc", pc0, 32'd7);
      check("halt_h", {31'd0, h0}, 32'd1);
      check("halt_valid", {31'd0, v0}, 32'd0);
      clear_ctrl();
      tick(); check("halt_frozen", pc0, 32'd7); check("halt_stays", {31'd0, h0}, 32'd1);
      #2 rst0 = 1;
      #1;
      check("async_pc", pc0, 32'd0);
      check("async_halted", {31'd0, h0}, 32'd0);
      check("async_state", {30'd0, s0}, 32'd0);

      // ---- DEPTH=16 instance: range boundary ----
      @(posedge clock); #1;
      rst1 = 0;
      tick(); check("d16_run", {31'd0, v1}, 32'd1);
      jump = 1; jump_target = 32'd15;
      tick(); check("d16_edge_ok", pc1, 32'd15); check("d16_no_err", {31'd0, e1}, 32'd0);
      jump_target = 32'd16;
      tick();
      check("d16_hold", pc1, 32'd15);
      check("d16_rerr", {31'd0, e1}, 32'd1);
      check("d16_halted", {31'd0, h1}, 32'd1);
      check("d16_valid", {31'd0, v1}, 32'd0);
      jump_target = 32'd3;
      tick(); check("d16_ignored", pc1, 32'd15); check("d16_sticky", {31'd0, e1}, 32'd1);
      clear_ctrl();
      #2 rst1 = 1;
      #1; check("d16_rerr_clr", {31'd0, e1}, 32'd0);

      // halt taken even with stall and a redirect present
      @(posedge clock); #1;
      rst1 = 0;
      tick();
      stall = 1; halt_req = 1; jump = 1; jump_target = 32'd9;
      tick(); check("stall_halt_h", {31'd0, h1}, 32'd1); check("stall_halt_pc", pc1, 32'd0);
      clear_ctrl();
      rst1 = 1;

      // ---- STEP=4, RESET_VECTOR=0x400 instance ----
      @(posedge clock); #1;
      check("s4_rst_pc", pc2, 32'h400);
      rst2 = 0;
      tick(); check("s4_pc0", pc2, 32'h400); check("s4_valid", {31'd0, v2}, 32'd1);
      tick(); check("s4_pc1", pc2, 32'h404);
      tick(); check("s4_pc2", pc2, 32'h408); check("s4_plus", pp2, 32'h40C);
      branch_taken = 1; branch_offset = -32'sd1;
      tick(); check("s4_br_m1", pc2, 32'h408);
      clear_ctrl();
      rst2 = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
